// File: rtl/axa_fetch_decode_pkg.sv
// AXA core shared definitions: instruction field positions,
// opcode constants, source-type codes and the decoded-field bundle.
package axa_fetch_decode_pkg;

  localparam logic [5:0] OP_SYS  = 6'h00;
  localparam logic [5:0] OP_FAIL = 6'h0F;

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_IMM4 = 2'b01;
  localparam logic [1:0] SRC_ADDR = 2'b10;
  localparam logic [1:0] SRC_UNDO = 2'b11;

  typedef struct packed {
    logic [5:0] op;
    logic [1:0] srctype;
    logic [3:0] src;
    logic [3:0] dest;
    logic [7:0] imm8;
    logic       illegal;
  } dec_t;

  function automatic logic [5:0] f_op6(
    input logic [15:0] ir
  );
    return ir[15:10];
  endfunction

  function automatic logic [3:0] f_op4(
    input logic [15:0] ir
  );
    return ir[15:12];
  endfunction

  function automatic logic f_immsize(
    input logic [15:0] ir
  );
    return ir[15];
  endfunction

  function automatic logic op_legal(
    input logic [5:0] op
  );
    return op inside {
      6'h00, 6'h01, [6'h02:6'h06],
      [6'h08:6'h0B], 6'h0E,
      [6'h10:6'h14]
    };
  endfunction

endpackage

// File: rtl/axa_fetch_decode_if.sv
// Fetch/decode stage bus: imem port, redirect/stall
// control and the stage-1 pipeline buffer outputs.
interface axa_fetch_decode_if;

  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        valid_o;
  logic [15:0] pc_o;
  logic [5:0]  op_o;
  logic [1:0]  srctype_o;
  logic [3:0]  src_o;
  logic [3:0]  dest_o;
  logic [7:0]  imm8_o;
  logic        illegal_o;
  logic        halt;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output valid_o,
    output pc_o,
    output op_o,
    output srctype_o,
    output src_o,
    output dest_o,
    output imm8_o,
    output illegal_o,
    output halt
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect,
    output redirect_pc,
    input  valid_o,
    input  pc_o,
    input  op_o,
    input  srctype_o,
    input  src_o,
    input  dest_o,
    input  imm8_o,
    input  illegal_o,
    input  halt
  );

endinterface

// File: rtl/axa_fetch_decode_inst_decode.sv
// Combinational AXA instruction decoder: splits one
// instruction word into op/srctype/src/dest/imm8 fields.
module axa_inst_decode
  import axa_fetch_decode_pkg::*;
(
  input  logic [15:0] i_ir,
  output dec_t        o_dec,
  output logic        o_is_sys
);

  logic [5:0] w_op6;

  assign w_op6 = f_op6(i_ir);

  always_comb begin
    o_dec         = '0;
    o_dec.src     = i_ir[7:4];
    o_dec.dest    = i_ir[3:0];
    o_dec.imm8    = i_ir[11:4];
    o_dec.srctype = i_ir[9:8];
    o_is_sys      = 1'b0;
    unique case (1'b1)
      f_immsize(i_ir): begin
        // 8-bit immediate ops carry no srctype field
        o_dec.op      = {f_op4(i_ir), 2'b00};
        o_dec.srctype = SRC_REG;
      end
      op_legal(w_op6): begin
        o_dec.op = w_op6;
        o_is_sys = (w_op6 == OP_SYS);
      end
      default: begin
        o_dec.op      = OP_FAIL;
        o_dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/axa_fetch_decode.sv
// AXA fetch + decode stage: PC, halt flag, stage-1 buffer
// and redirect/stall/halt priority.
module axa_fetch_decode
  import axa_fetch_decode_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  axa_fetch_decode_if.master    bus
);

  logic [15:0] r_pc;
  logic [15:0] r_pc_o;
  logic        r_valid;
  logic        r_halt;
  dec_t        r_dec;
  dec_t        w_dec;
  logic        w_is_sys;

  axa_inst_decode u_dec (
    .i_ir     (bus.imem_data),
    .o_dec    (w_dec),
    .o_is_sys (w_is_sys)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_pc_o  <= '0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_dec   <= '0;
    end else if (r_halt) begin
      r_valid <= 1'b0;
    end else if (bus.redirect) begin
      r_pc    <= bus.redirect_pc;
      r_valid <= 1'b0;
    end else if (bus.stall) begin
      r_valid <= r_valid;
    end else if (w_is_sys) begin
      r_halt  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_dec   <= w_dec;
      r_valid <= 1'b1;
      r_pc_o  <= r_pc;
      r_pc    <= r_pc + 16'h0001;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.valid_o   = r_valid;
  assign bus.pc_o      = r_pc_o;
  assign bus.op_o      = r_dec.op;
  assign bus.srctype_o = r_dec.srctype;
  assign bus.src_o     = r_dec.src;
  assign bus.dest_o    = r_dec.dest;
  assign bus.imm8_o    = r_dec.imm8;
  assign bus.illegal_o = r_dec.illegal;
  assign bus.halt      = r_halt;

endmodule

// File: tb/tb_axa_fetch_decode.sv
// Directed bench for axa_fetch_decode: fetch, stall,
// redirect, halt, illegal decode and PC wraparound.
module tb_axa_fetch_decode;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;
  logic done = 1'b0;

  logic [15:0] mem [0:65535];

  axa_fetch_decode_if a_if ();
  axa_fetch_decode_if b_if ();

  axa_fetch_decode #(.RESET_PC(16'h0000)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.master)
  );

  axa_fetch_decode #(.RESET_PC(16'hFFFF)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.master)
  );

  assign a_if.imem_data = mem[a_if.imem_addr];
  assign b_if.imem_data = mem[b_if.imem_addr];
  assign b_if.stall       = 1'b0;
  assign b_if.redirect    = 1'b0;
  assign b_if.redirect_pc = 16'h0000;

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
        tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      nerr++;
      $error("FAIL timeout: bench did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
        ncmp, nerr);
      $finish;
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0421;
    mem[0] = 16'h0821;
    mem[1] = 16'hC5A3;
    mem[2] = 16'h4023;
    mem[5] = 16'h0000;
    mem[6] = 16'h1C00;
    a_if.stall       = 1'b0;
    a_if.redirect    = 1'b0;
    a_if.redirect_pc = 16'h0000;

    // reset state
    step(); step();
    chk("rst_valid", a_if.valid_o, 1'b0);
    chk("rst_halt", a_if.halt, 1'b0);
    chk("rst_ill", a_if.illegal_o, 1'b0);
    chk("rst_pc_o", a_if.pc_o, 16'h0000);
    chk("rst_op", a_if.op_o, 6'h00);
    chk("rst_addr", a_if.imem_addr, 16'h0000);
    chk("rstb_addr", b_if.imem_addr, 16'hFFFF);
    reset = 1'b1;

    // test 1: 0821
    step();
    chk("t1_valid", a_if.valid_o, 1'b1);
    chk("t1_pc_o", a_if.pc_o, 16'h0000);
    chk("t1_op", a_if.op_o, 6'h02);
    chk("t1_src", a_if.src_o, 4'h2);
    chk("t1_dest", a_if.dest_o, 4'h1);
    chk("t1_stype", a_if.srctype_o, 2'b00);
    chk("t1_addr", a_if.imem_addr, 16'h0001);
    chk("wrap_pc_o0", b_if.pc_o, 16'hFFFF);
    chk("wrap_addr", b_if.imem_addr, 16'h0000);

    // test 2: lhi C5A3
    step();
    chk("t2_op", a_if.op_o, 6'h30);
    chk("t2_imm8", a_if.imm8_o, 8'h5A);
    chk("t2_dest", a_if.dest_o, 4'h3);
    chk("t2_stype", a_if.srctype_o, 2'b00);
    chk("t2_ill", a_if.illegal_o, 1'b0);
    chk("t2_pc_o", a_if.pc_o, 16'h0001);
    chk("wrap_pc_o1", b_if.pc_o, 16'h0000);

    // test 3: stall 3 cycles
    a_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_op", a_if.op_o, 6'h30);
      chk("t3_pc_o", a_if.pc_o, 16'h0001);
      chk("t3_valid", a_if.valid_o, 1'b1);
      chk("t3_addr", a_if.imem_addr, 16'h0002);
    end
    a_if.stall = 1'b0;
    step();
    chk("t3r_pc_o", a_if.pc_o, 16'h0002);
    chk("t3r_op", a_if.op_o, 6'h10);
    chk("t3r_dest", a_if.dest_o, 4'h3);
    chk("t3r_addr", a_if.imem_addr, 16'h0003);

    // test 4: redirect overrides stall
    a_if.stall       = 1'b1;
    a_if.redirect    = 1'b1;
    a_if.redirect_pc = 16'h0040;
    step();
    chk("t4_valid", a_if.valid_o, 1'b0);
    chk("t4_addr", a_if.imem_addr, 16'h0040);
    a_if.stall    = 1'b0;
    a_if.redirect = 1'b0;
    step();
    chk("t4_pc_o", a_if.pc_o, 16'h0040);
    chk("t4_valid2", a_if.valid_o, 1'b1);
    chk("t4_op", a_if.op_o, 6'h01);
    chk("t4_addr2", a_if.imem_addr, 16'h0041);

    // test 5: sys halts, redirect ignored, reset clears
    a_if.redirect    = 1'b1;
    a_if.redirect_pc = 16'h0005;
    step();
    a_if.redirect = 1'b0;
    step();
    chk("t5_halt", a_if.halt, 1'b1);
    chk("t5_valid", a_if.valid_o, 1'b0);
    chk("t5_addr", a_if.imem_addr, 16'h0005);
    a_if.redirect    = 1'b1;
    a_if.redirect_pc = 16'h0040;
    step();
    chk("t5_hold_addr", a_if.imem_addr, 16'h0005);
    chk("t5_hold_halt", a_if.halt, 1'b1);
    chk("t5_hold_pc_o", a_if.pc_o, 16'h0040);
    a_if.redirect = 1'b0;
    reset = 1'b0;
    #1;
    chk("t5_rst_halt", a_if.halt, 1'b0);
    chk("t5_rst_addr", a_if.imem_addr, 16'h0000);
    chk("t5_rst_pc_o", a_if.pc_o, 16'h0000);
    reset = 1'b1;

    // test 6: illegal op 07
    a_if.redirect    = 1'b1;
    a_if.redirect_pc = 16'h0006;
    step();
    a_if.redirect = 1'b0;
    step();
    chk("t6_op", a_if.op_o, 6'h0F);
    chk("t6_ill", a_if.illegal_o, 1'b1);
    chk("t6_valid", a_if.valid_o, 1'b1);
    chk("t6_pc_o", a_if.pc_o, 16'h0006);
    step();
    chk("t6_next_ill", a_if.illegal_o, 1'b0);
    chk("t6_next_op", a_if.op_o, 6'h01);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      ncmp, nerr);
    $finish;
  end

endmodule
